// File: rtl/gamma_lut_multi.sv
// gamma_lut_multi: per-channel double-buffered gamma tables with a frame-synchronous bank swap.
// Define GAMMA_LUT_BYPASS_EN to compile in the optional `bypass` input (raw pixel, same latency).
module gamma_lut_multi #(
   parameter int    C_CHANNELS   = 3,
   parameter int    C_DATA_WIDTH = 8,
   parameter string C_INIT_FILE  = "NONE"
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   input  logic                               in_vsync,
   input  logic [C_CHANNELS*C_DATA_WIDTH-1:0] in_data,
   output logic                               out_valid,
   output logic                               out_vsync,
   output logic [C_CHANNELS*C_DATA_WIDTH-1:0] out_data,
   input  logic                               lut_wr_en,
   input  logic [1:0]                         lut_wr_chan,
   input  logic [C_DATA_WIDTH-1:0]            lut_wr_addr,
   input  logic [C_DATA_WIDTH-1:0]            lut_wr_data,
   input  logic                               lut_commit,
`ifdef GAMMA_LUT_BYPASS_EN
   input  logic                               bypass,
`endif
   output logic                               lut_busy,
   output logic                               active_bank
);

   localparam int DEPTH = 1 << C_DATA_WIDTH;
   localparam int PIX_W = C_CHANNELS * C_DATA_WIDTH;

   typedef logic [DEPTH-1:0][C_DATA_WIDTH-1:0] table_t;

   if (C_CHANNELS < 1 || C_CHANNELS > 4) begin : g_bad_channels
      $error("gamma_lut_multi: C_CHANNELS must be in 1..4");
   end
   if (C_DATA_WIDTH < 8 || C_DATA_WIDTH > 12) begin : g_bad_width
      $error("gamma_lut_multi: C_DATA_WIDTH must be in 8..12");
   end
   if (C_INIT_FILE != "NONE") begin : g_init_file
      $warning("gamma_lut_multi: C_INIT_FILE is not loaded; tables start as identity");
   end

   // Power-on table image: identity.
   function automatic table_t init_table();
      table_t img;
      for (int i = 0; i < DEPTH; i++) img[i] = C_DATA_WIDTH'(i);
      return img;
   endfunction

   logic             vsync_q;
   logic             frame_start;
   logic             swap;
   logic             pix_bank;
   logic             s1_valid;
   logic             s1_vsync;
   logic             s1_bank;
   logic             s1_bypass;
   logic [PIX_W-1:0] s1_data;
   logic [PIX_W-1:0] lut_rd;
   logic [PIX_W-1:0] pix_result;

   assign frame_start = in_vsync && !vsync_q;
   assign swap        = frame_start && (lut_busy || lut_commit);
   // A pixel arriving in the swap cycle already belongs to the new frame.
   assign pix_bank    = swap ? !active_bank : active_bank;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q     <= 1'b0;
         lut_busy    <= 1'b0;
         active_bank <= 1'b0;
      end else begin
         vsync_q <= in_vsync;
         if (swap) begin
            active_bank <= !active_bank;
            lut_busy    <= 1'b0;
         end else if (lut_commit) begin
            lut_busy <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_vsync <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         s1_vsync <= in_vsync;
      end
   end

   // Payload registers are qualified by s1_valid, so they carry no reset.
   always_ff @(posedge clk) begin
      s1_data <= in_data;
      s1_bank <= pix_bank;
   end

`ifdef GAMMA_LUT_BYPASS_EN
   always_ff @(posedge clk) begin
      s1_bypass <= bypass;
   end
`else
   assign s1_bypass = 1'b0;
`endif

   for (genvar c = 0; c < C_CHANNELS; c++) begin : g_chan
      // NOTE: table storage is never reset; contents survive rst and come only from the power-on image.
      table_t                  bank0 = init_table();
      table_t                  bank1 = init_table();
      logic                    wr_hit;
      logic [C_DATA_WIDTH-1:0] rd_addr;

      // Writes always land in the bank not currently selected for reads.
      assign wr_hit  = lut_wr_en && !rst && (lut_wr_chan == 2'(c));
      assign rd_addr = s1_data[c*C_DATA_WIDTH +: C_DATA_WIDTH];

      always_ff @(posedge clk) begin
         if (wr_hit && active_bank)  bank0[lut_wr_addr] <= lut_wr_data;
         if (wr_hit && !active_bank) bank1[lut_wr_addr] <= lut_wr_data;
      end

      assign lut_rd[c*C_DATA_WIDTH +: C_DATA_WIDTH] = s1_bank ? bank1[rd_addr] : bank0[rd_addr];
   end

   assign pix_result = s1_bypass ? s1_data : lut_rd;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_vsync <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= s1_valid;
         out_vsync <= s1_vsync;
         if (s1_valid) out_data <= pix_result;
      end
   end

endmodule

// File: tb/tb_gamma_lut_multi.sv
// tb_gamma_lut_multi: directed vector table, reset-in-stream sequence and random traffic,
// all checked against a frame-level reference model of the double-buffered gamma tables.
module tb_gamma_lut_multi;

   localparam int CH = 3;
   localparam int W  = 8;
   localparam int PW = CH * W;

   typedef struct {
      bit            rst;
      bit            valid;
      bit            vsync;
      logic [PW-1:0] data;
      bit            wr_en;
      logic [1:0]    chan;
      logic [W-1:0]  addr;
      logic [W-1:0]  wdata;
      bit            commit;
   } stim_t;

   typedef struct {
      stim_t         s;
      bit            e_valid;
      logic [PW-1:0] e_data;
      bit            e_busy;
      bit            e_bank;
   } vec_t;

   typedef struct {
      bit            v;
      bit            vs;
      logic [PW-1:0] d;
      bit            bank;
      bit            byp;
   } pend_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_vsync = 1'b0;
   logic [PW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_vsync;
   logic [PW-1:0] out_data;
   logic          lut_wr_en = 1'b0;
   logic [1:0]    lut_wr_chan = '0;
   logic [W-1:0]  lut_wr_addr = '0;
   logic [W-1:0]  lut_wr_data = '0;
   logic          lut_commit = 1'b0;
   logic          bypass = 1'b0;
   logic          lut_busy;
   logic          active_bank;

   int total = 0;
   int bad   = 0;

   // Reference model: full table contents per channel and bank, plus frame-level swap state.
   logic [W-1:0]  m_tbl [CH][2][1<<W];
   bit            m_bank;
   bit            m_busy;
   bit            m_vq;
   pend_t         m_pend;
   bit            e_valid;
   bit            e_vsync;
   logic [PW-1:0] e_data;

   vec_t vecs[$];

   always #5 clk = ~clk;

   gamma_lut_multi #(
      .C_CHANNELS  (CH),
      .C_DATA_WIDTH(W),
      .C_INIT_FILE ("NONE")
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_vsync   (in_vsync),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_vsync  (out_vsync),
      .out_data   (out_data),
      .lut_wr_en  (lut_wr_en),
      .lut_wr_chan(lut_wr_chan),
      .lut_wr_addr(lut_wr_addr),
      .lut_wr_data(lut_wr_data),
      .lut_commit (lut_commit),
`ifdef GAMMA_LUT_BYPASS_EN
      .bypass     (bypass),
`endif
      .lut_busy   (lut_busy),
      .active_bank(active_bank)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic stim_t st(bit r, bit v, bit vs, logic [PW-1:0] d,
                                bit we, logic [1:0] ch, logic [W-1:0] a, logic [W-1:0] wd, bit cm);
      stim_t s;
      s.rst = r; s.valid = v; s.vsync = vs; s.data = d;
      s.wr_en = we; s.chan = ch; s.addr = a; s.wdata = wd; s.commit = cm;
      return s;
   endfunction

   task automatic add(input stim_t s, input bit ev, input logic [PW-1:0] ed, input bit eb, input bit ek);
      vec_t v;
      v.s = s; v.e_valid = ev; v.e_data = ed; v.e_busy = eb; v.e_bank = ek;
      vecs.push_back(v);
   endtask

   function automatic logic [PW-1:0] lookup(logic [PW-1:0] d, bit b);
      logic [PW-1:0] r;
      for (int c = 0; c < CH; c++) r[c*W +: W] = m_tbl[c][b][d[c*W +: W]];
      return r;
   endfunction

   // A captured pixel is looked up on the following edge and sees every write accepted before that edge.
   task automatic model_step(input stim_t s);
      bit fs, sw, nb;
      if (s.rst) begin
         e_valid = 1'b0; e_vsync = 1'b0; e_data = '0;
         m_pend  = '{default: '0};
         m_bank  = 1'b0; m_busy = 1'b0; m_vq = 1'b0;
      end else begin
         e_valid = m_pend.v;
         e_vsync = m_pend.vs;
         if (m_pend.v) e_data = m_pend.byp ? m_pend.d : lookup(m_pend.d, m_pend.bank);
         if (s.wr_en && int'(s.chan) < CH) m_tbl[s.chan][!m_bank][s.addr] = s.wdata;
         fs = s.vsync && !m_vq;
         sw = fs && (m_busy || s.commit);
         nb = sw ? !m_bank : m_bank;
         m_pend = '{v: s.valid, vs: s.vsync, d: s.data, bank: nb, byp: bypass};
         if (sw) begin
            m_bank = nb;
            m_busy = 1'b0;
         end else if (s.commit) begin
            m_busy = 1'b1;
         end
         m_vq = s.vsync;
      end
   endtask

   task automatic apply(input stim_t s);
      @(negedge clk);
      rst = s.rst; in_valid = s.valid; in_vsync = s.vsync; in_data = s.data;
      lut_wr_en = s.wr_en; lut_wr_chan = s.chan; lut_wr_addr = s.addr;
      lut_wr_data = s.wdata; lut_commit = s.commit;
      model_step(s);
      @(posedge clk);
      #1;
      check("model.out_valid",   32'(out_valid),   32'(e_valid));
      check("model.out_vsync",   32'(out_vsync),   32'(e_vsync));
      check("model.out_data",    32'(out_data),    32'(e_data));
      check("model.lut_busy",    32'(lut_busy),    32'(m_busy));
      check("model.active_bank", 32'(active_bank), 32'(m_bank));
   endtask

   initial begin
      bit            vs;
      logic [PW-1:0] d;

      for (int c = 0; c < CH; c++)
         for (int b = 0; b < 2; b++)
            for (int a = 0; a < (1 << W); a++) m_tbl[c][b][a] = W'(a);
      m_bank = 1'b0; m_busy = 1'b0; m_vq = 1'b0;
      m_pend = '{default: '0};
      e_valid = 1'b0; e_vsync = 1'b0; e_data = '0;

      // Expected values are the outputs right after the row's clock edge.
      add(st(1, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 0, 24'h000000, 0, 0);
      add(st(0, 1, 0, 24'hC08040, 0, 0, 8'h00, 8'h00, 0), 0, 24'h000000, 0, 0);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'hC08040, 0, 0);
      add(st(0, 0, 0, 24'h000000, 1, 0, 8'h10, 8'hFF, 0), 0, 24'hC08040, 0, 0);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 1), 0, 24'hC08040, 1, 0);
      add(st(0, 1, 0, 24'h000010, 0, 0, 8'h00, 8'h00, 0), 0, 24'hC08040, 1, 0);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'h000010, 1, 0);
      add(st(0, 1, 1, 24'h000010, 0, 0, 8'h00, 8'h00, 0), 0, 24'h000010, 0, 1);
      add(st(0, 0, 1, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'h0000FF, 0, 1);
      add(st(0, 1, 0, 24'h000010, 1, 3, 8'h10, 8'h55, 0), 0, 24'h0000FF, 0, 1);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 1), 1, 24'h0000FF, 1, 1);
      add(st(0, 1, 1, 24'h101010, 0, 0, 8'h00, 8'h00, 0), 0, 24'h0000FF, 0, 0);
      add(st(0, 0, 1, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'h101010, 0, 0);
      add(st(0, 0, 0, 24'h000000, 1, 1, 8'h20, 8'h77, 0), 0, 24'h101010, 0, 0);
      add(st(0, 1, 1, 24'h002000, 0, 0, 8'h00, 8'h00, 1), 0, 24'h101010, 0, 1);
      add(st(0, 0, 1, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'h007700, 0, 1);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 1), 0, 24'h007700, 1, 1);
      add(st(0, 1, 1, 24'h300000, 1, 2, 8'h30, 8'h99, 0), 0, 24'h007700, 0, 0);
      add(st(0, 0, 1, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 1, 24'h990000, 0, 0);
      add(st(0, 1, 0, 24'h000010, 0, 0, 8'h00, 8'h00, 0), 0, 24'h990000, 0, 0);
      add(st(0, 0, 0, 24'h000000, 1, 0, 8'h10, 8'h11, 0), 1, 24'h000010, 0, 0);
      add(st(0, 0, 0, 24'h000000, 0, 0, 8'h00, 8'h00, 0), 0, 24'h000010, 0, 0);

      foreach (vecs[k]) begin
         apply(vecs[k].s);
         check($sformatf("vec%0d.out_valid", k),   32'(out_valid),   32'(vecs[k].e_valid));
         check($sformatf("vec%0d.out_data", k),    32'(out_data),    32'(vecs[k].e_data));
         check($sformatf("vec%0d.lut_busy", k),    32'(lut_busy),    32'(vecs[k].e_busy));
         check($sformatf("vec%0d.active_bank", k), 32'(active_bank), 32'(vecs[k].e_bank));
      end

      // Move to bank 1, then reset in the middle of a continuous pixel stream.
      apply(st(0, 0, 0, 24'h0, 0, 0, 8'h00, 8'h00, 1));
      apply(st(0, 0, 1, 24'h0, 0, 0, 8'h00, 8'h00, 0));
      check("pre_stream.active_bank", 32'(active_bank), 32'd1);
      for (int p = 0; p < 256; p++) begin
         apply(st(p == 100, 1, 0, PW'($urandom), 0, 0, 8'h00, 8'h00, 0));
         if (p == 100) begin
            check("stream_rst.out_valid",   32'(out_valid),   32'd0);
            check("stream_rst.active_bank", 32'(active_bank), 32'd0);
            check("stream_rst.lut_busy",    32'(lut_busy),    32'd0);
         end
      end

      // Tables written before the reset are still there once bank 1 is reselected.
      apply(st(0, 1, 1, 24'h002010, 0, 0, 8'h00, 8'h00, 1));
      check("post_rst_swap.active_bank", 32'(active_bank), 32'd1);
      apply(st(0, 0, 1, 24'h0, 0, 0, 8'h00, 8'h00, 0));
      check("post_rst_swap.out_data", 32'(out_data), 32'h007711);

`ifdef GAMMA_LUT_BYPASS_EN
      bypass = 1'b1;
      apply(st(0, 1, 1, 24'h000010, 0, 0, 8'h00, 8'h00, 0));
      bypass = 1'b0;
      apply(st(0, 0, 1, 24'h0, 0, 0, 8'h00, 8'h00, 0));
      check("bypass.out_data", 32'(out_data), 32'h000010);
`endif

      vs = 1'b1;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 7) == 0) vs = !vs;
         d = PW'($urandom) & 24'h1F1F1F;
         apply(st($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, vs, d,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  W'($urandom_range(0, 31)), W'($urandom), $urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gamma_lut_multi.md
GAMMA_LUT_MULTI -- requirements
Module: gamma_lut_multi

Interface
REQ-001 SHALL provide parameter C_CHANNELS, default 3, meaning number of independent colour channels (legal 1~4).
REQ-002 SHALL provide parameter C_DATA_WIDTH, default 8, meaning per-channel pixel width and table address width (legal 8~12).
REQ-003 SHALL provide parameter C_INIT_FILE, default "NONE", meaning hex file loaded into both banks of every channel; "NONE" means identity table.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, input pixel qualifier.
REQ-007 SHALL have port in_vsync, input, 1, frame sync level.
REQ-008 SHALL have port in_data, input, C_CHANNELS*C_DATA_WIDTH, packed pixel, channel 0 in LSBs.
REQ-009 SHALL have port out_valid, input-aligned delayed qualifier, output, 1.
REQ-010 SHALL have port out_vsync, output, 1, in_vsync delayed to match out_data.
REQ-011 SHALL have port out_data, output, C_CHANNELS*C_DATA_WIDTH, corrected pixel.
REQ-012 SHALL have ports lut_wr_en (input, 1), lut_wr_chan (input, 2), lut_wr_addr (input, C_DATA_WIDTH), lut_wr_data (input, C_DATA_WIDTH): shadow-table write port.
REQ-013 SHALL have port lut_commit, input, 1, request bank swap at next frame start.
REQ-014 SHALL have ports lut_busy (output, 1, swap pending) and active_bank (output, 1, bank in use).

Function
REQ-015 SHALL hold two banks of 2^C_DATA_WIDTH x C_DATA_WIDTH per channel; reads use active_bank, writes use the other bank.
REQ-016 SHALL perform lookup with fixed latency 2: cycle N input registered and table read, cycle N+2 out_data/out_valid/out_vsync valid.
REQ-017 SHALL accept one pixel per cycle with no backpressure; out_valid=0 cycles SHALL leave out_data holding its last value.
REQ-018 SHALL write lut_wr_data to shadow bank of channel lut_wr_chan at lut_wr_addr when lut_wr_en=1; lut_wr_chan >= C_CHANNELS SHALL be ignored.
REQ-019 SHALL set lut_busy on lut_commit=1; lut_commit while lut_busy=1 SHALL have no additional effect.
REQ-020 SHALL detect frame start as in_vsync=1 with previous-cycle in_vsync=0; on frame start with lut_busy=1 (or lut_commit=1 same cycle) SHALL toggle active_bank and clear lut_busy on the same edge.
REQ-021 SHALL latch bank select with each pixel in stage 1 so pixels entering on or after the swap cycle use the new bank, earlier pixels the old bank.
REQ-022 SHALL keep shadow writes accepted while lut_busy=1; a write in the swap cycle SHALL target the pre-swap shadow bank.
REQ-023 SHALL give lookup read of an address written the same cycle (shadow) no effect on output (different bank).

Reset
REQ-024 SHALL on rst=1 clear out_valid, out_vsync, out_data, lut_busy, active_bank and the vsync edge register to 0 at the next clk edge.
REQ-025 SHALL discard in-flight pixels on reset mid-stream; table contents SHALL NOT be altered by reset.
REQ-026 SHALL ignore lut_wr_en and lut_commit while rst=1.

Configuration
REQ-027 SHALL compile a bypass input port (1 bit) only when macro GAMMA_LUT_BYPASS_EN is defined.
REQ-028 With GAMMA_LUT_BYPASS_EN and bypass=1, out_data SHALL equal in_data delayed 2 cycles (latency unchanged); bank logic SHALL continue operating.
REQ-029 Without GAMMA_LUT_BYPASS_EN, no bypass port SHALL exist and lookup SHALL always apply.

Verification
REQ-030 Reset, identity table, C_CHANNELS=3: in_data=0xC08040 valid cycle N -> out_data=0xC08040, out_valid=1 at N+2.
REQ-031 Write chan0 addr 0x10 data 0xFF, commit, no vsync: pixel 0x000010 -> 0x000010, lut_busy=1; after vsync rise -> 0x0000FF, lut_busy=0, active_bank=1.
REQ-032 lut_commit and vsync rise same cycle -> active_bank toggles that edge; pixel entering that cycle uses new bank.
REQ-033 Continuous valid stream of 256 pixels with rst asserted at pixel 100 -> out_valid=0 next cycle, active_bank=0, lut_busy=0, table written earlier still readable after swap.
REQ-034 GAMMA_LUT_BYPASS_EN defined, bypass=1, chan0 table non-identity: in_data=0x000010 -> out_data=0x000010 at N+2.
REQ-035 lut_wr_chan=3 with C_CHANNELS=3, commit, vsync rise -> all channels unchanged from prior tables.
